// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with a per-register pending-write scoreboard.
// Define RR_ARB_EN for round-robin arbitration; the default build uses fixed priority.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]    reqValid,
    input  logic [NREQ*AW-1:0] reqAddr,
    input  logic [NREQ*DW-1:0] reqData,
    output logic [NREQ-1:0]    reqReady,
    input  logic             reserveValid,
    input  logic [AW-1:0]    reserveAddr,
    input  logic [AW-1:0]    checkAddr1,
    input  logic [AW-1:0]    checkAddr2,
    output logic             hazard,
    output logic             regWrite,
    output logic [AW-1:0]    writeRegister,
    output logic [DW-1:0]    writeData,
    output logic             sbOverflow,
    output logic             sbUnderflow
);
    localparam int NREG = 1 << AW;
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   win_idx_s;
    logic            win_found_s;
    logic [NREQ-1:0] grant_s;
    logic [AW-1:0]   win_addr_s;
    logic [DW-1:0]   win_data_s;

    logic            reg_write_q, reg_write_d;
    logic [AW-1:0]   write_register_q, write_register_d;
    logic [DW-1:0]   write_data_q, write_data_d;
    logic            sb_overflow_q, sb_overflow_d;
    logic            sb_underflow_q, sb_underflow_d;
    logic [2:0]      cnt_q [NREG];
    logic [2:0]      cnt_d [NREG];
    logic            inc_s, dec_s;

`ifdef RR_ARB_EN
    logic [PW-1:0] ptr_q, ptr_d;

    // Round-robin search; walking backwards lets the nearest index after ptr win
    always_comb begin
        win_idx_s   = '0;
        win_found_s = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (reqValid[PW'((int'(ptr_q) + k) % NREQ)]) begin
                win_idx_s   = PW'((int'(ptr_q) + k) % NREQ);
                win_found_s = 1'b1;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Pointer moves to the winner only when a transfer happens
    always_comb begin
        if (win_found_s) begin
            ptr_d = win_idx_s;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register; reset value makes index 0 the first one served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: lowest valid index wins
    always_comb begin
        win_idx_s   = '0;
        win_found_s = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (reqValid[PW'(i)]) begin
                win_idx_s   = PW'(i);
                win_found_s = 1'b1;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end
`endif

    // One-hot grant and winner payload select
    always_comb begin
        grant_s = '0;
        if (win_found_s) begin
            grant_s[win_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
        win_addr_s = reqAddr[win_idx_s*AW +: AW];
        win_data_s = reqData[win_idx_s*DW +: DW];
    end

    // Write stage next state; address 0 is accepted but never written
    always_comb begin
        reg_write_d = win_found_s && (win_addr_s != '0);
        if (win_found_s) begin
            write_register_d = win_addr_s;
            write_data_d     = win_data_s;
        end else begin
            write_register_d = write_register_q;
            write_data_d     = write_data_q;
        end
    end

    // Scoreboard next state; the retire comes from the live write stage
    always_comb begin
        cnt_d          = cnt_q;
        sb_overflow_d  = sb_overflow_q;
        sb_underflow_d = sb_underflow_q;
        inc_s          = 1'b0;
        dec_s          = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            inc_s = reserveValid && (reserveAddr == AW'(r));
            dec_s = reg_write_q && (write_register_q == AW'(r));
            case ({inc_s, dec_s})
                2'b10: begin
                    if (cnt_q[AW'(r)] == 3'd7) begin
                        sb_overflow_d = 1'b1;
                    end else begin
                        cnt_d[AW'(r)] = cnt_q[AW'(r)] + 3'd1;
                    end
                end
                2'b01: begin
                    if (cnt_q[AW'(r)] == 3'd0) begin
                        sb_underflow_d = 1'b1;
                    end else begin
                        cnt_d[AW'(r)] = cnt_q[AW'(r)] - 3'd1;
                    end
                end
                default: cnt_d[AW'(r)] = cnt_q[AW'(r)];
            endcase
        end
    end

    // State registers; reset discards any in-flight write without retiring it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
            sb_overflow_q    <= 1'b0;
            sb_underflow_q   <= 1'b0;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= 3'd0;
            end
        end else begin
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
            sb_overflow_q    <= sb_overflow_d;
            sb_underflow_q   <= sb_underflow_d;
            cnt_q            <= cnt_d;
        end
    end

    assign reqReady      = grant_s;
    assign hazard        = (cnt_q[checkAddr1] != 3'd0) || (cnt_q[checkAddr2] != 3'd0);
    assign regWrite      = reg_write_q;
    assign writeRegister = write_register_q;
    assign writeData     = write_data_q;
    assign sbOverflow    = sb_overflow_q;
    assign sbUnderflow   = sb_underflow_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized
// traffic against a count-level reference model (honours RR_ARB_EN).
module tb_regfile_wb_arbiter;
    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    ready;
    logic               reserve_valid;
    logic [AW-1:0]      reserve_addr;
    logic [AW-1:0]      check1, check2;
    logic               hazard, reg_write, sb_ovf, sb_unf;
    logic [AW-1:0]      write_register;
    logic [DW-1:0]      write_data;

    int checks = 0;
    int fails  = 0;

    int          m_cnt [32];
    int          m_ptr;
    bit          m_we;
    int          m_wr;
    logic [DW-1:0] m_wd;
    bit          m_ovf, m_unf;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(req_valid), .reqAddr(req_addr), .reqData(req_data), .reqReady(ready),
        .reserveValid(reserve_valid), .reserveAddr(reserve_addr),
        .checkAddr1(check1), .checkAddr2(check2), .hazard(hazard),
        .regWrite(reg_write), .writeRegister(write_register), .writeData(write_data),
        .sbOverflow(sb_ovf), .sbUnderflow(sb_unf)
    );

    function automatic int model_grant();
`ifdef RR_ARB_EN
        for (int k = 1; k <= NREQ; k++) begin
            int idx = (m_ptr + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic bit model_hazard();
        return (m_cnt[check1] != 0) || (m_cnt[check2] != 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_ptr = NREQ - 1; m_we = 1'b0; m_wr = 0; m_wd = '0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs currently applied
    task automatic model_step();
        int g;
        int ra;
        bit inc;
        g   = model_grant();
        ra  = int'(reserve_addr);
        inc = reserve_valid && (ra != 0);
        if (!(inc && m_we && ra == m_wr)) begin
            if (m_we) begin
                if (m_cnt[m_wr] == 0) m_unf = 1'b1; else m_cnt[m_wr] = m_cnt[m_wr] - 1;
            end
            if (inc) begin
                if (m_cnt[ra] == 7) m_ovf = 1'b1; else m_cnt[ra] = m_cnt[ra] + 1;
            end
        end
        if (g >= 0) begin
            m_wr  = int'(req_addr[g*AW +: AW]);
            m_wd  = req_data[g*DW +: DW];
            m_we  = (m_wr != 0);
            m_ptr = g;
        end else begin
            m_we = 1'b0;
        end
    endtask

    task automatic clr_inputs();
        req_valid = '0; req_addr = '0; req_data = '0;
        reserve_valid = 1'b0; reserve_addr = '0; check1 = '0; check2 = '0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        model_reset();
    endtask

    task automatic test_reset();
        clr_inputs();
        rst_n = 1'b0;
        #2;
        checks++; if (reg_write !== 1'b0 || write_register !== '0 || write_data !== '0) begin
            fails++; $display("FAIL reset_regs: got we=%0b wr=%0d wd=%0h expected 0/0/0", reg_write, write_register, write_data); end
        do_reset();
        for (int c = 0; c < 4; c++) begin
            check1 = AW'($urandom_range(0, 31)); check2 = AW'($urandom_range(0, 31));
            #1;
            checks++; if (ready !== 3'b000 || hazard !== 1'b0) begin
                fails++; $display("FAIL idle_comb: got ready=%b hazard=%0b expected 000/0", ready, hazard); end
            checks++; if (reg_write !== 1'b0 || write_register !== '0 || write_data !== '0) begin
                fails++; $display("FAIL idle_regs: got we=%0b wr=%0d wd=%0h expected 0/0/0", reg_write, write_register, write_data); end
            tick();
        end
    endtask

    task automatic test_single();
        do_reset();
        set_req(1, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b010;
        #1;
        checks++; if (ready !== 3'b010) begin
            fails++; $display("FAIL single_grant: got %b expected 010", ready); end
        tick();
        req_valid = 3'b000;
        checks++; if (reg_write !== 1'b1 || write_register !== 5'd5 || write_data !== 32'hDEADBEEF) begin
            fails++; $display("FAIL single_write: got we=%0b wr=%0d wd=%0h expected 1/5/deadbeef", reg_write, write_register, write_data); end
        tick();
        checks++; if (reg_write !== 1'b0 || write_data !== 32'hDEADBEEF) begin
            fails++; $display("FAIL single_once: got we=%0b wd=%0h expected 0/deadbeef", reg_write, write_data); end
    endtask

    task automatic test_back_to_back();
        int idx, prev;
        logic [NREQ-1:0] exp_g;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(10 + i), 32'h100 + i);
        req_valid = 3'b111;
        prev = -1;
        for (int c = 0; c < 6; c++) begin
`ifdef RR_ARB_EN
            idx = c % NREQ;
`else
            idx = 0;
`endif
            if (prev >= 0) begin
                checks++; if (reg_write !== 1'b1 || write_register !== AW'(10 + prev)) begin
                    fails++; $display("FAIL b2b_write%0d: got we=%0b wr=%0d expected 1/%0d", c, reg_write, write_register, 10 + prev); end
            end
            #1;
            exp_g = '0; exp_g[idx] = 1'b1;
            checks++; if (ready !== exp_g) begin
                fails++; $display("FAIL b2b_grant%0d: got %b expected %b", c, ready, exp_g); end
            tick();
            prev = idx;
        end
        req_valid = '0;
        checks++; if (reg_write !== 1'b1 || write_data !== 32'h100 + prev) begin
            fails++; $display("FAIL b2b_last: got we=%0b wd=%0h expected 1/%0h", reg_write, write_data, 32'h100 + prev); end
    endtask

    task automatic test_hazard();
        do_reset();
        check1 = 5'd7; check2 = 5'd0;
        set_req(0, 5'd7, 32'h77);
        reserve_valid = 1'b1; reserve_addr = 5'd7;
        tick(); tick();
        reserve_valid = 1'b0;
        checks++; if (hazard !== 1'b1) begin fails++; $display("FAIL haz_reserved: got %0b expected 1", hazard); end
        req_valid = 3'b001; tick(); req_valid = 3'b000;
        tick();
        checks++; if (hazard !== 1'b1) begin fails++; $display("FAIL haz_first_retire: got %0b expected 1", hazard); end
        req_valid = 3'b001; tick(); req_valid = 3'b000;
        checks++; if (hazard !== 1'b1) begin fails++; $display("FAIL haz_in_stage: got %0b expected 1", hazard); end
        tick();
        checks++; if (hazard !== 1'b0) begin fails++; $display("FAIL haz_second_retire: got %0b expected 0", hazard); end
        reserve_valid = 1'b1; tick(); reserve_valid = 1'b0;
        req_valid = 3'b001; tick(); req_valid = 3'b000;
        reserve_valid = 1'b1; tick(); reserve_valid = 1'b0;
        checks++; if (hazard !== 1'b1 || sb_ovf !== 1'b0 || sb_unf !== 1'b0) begin
            fails++; $display("FAIL haz_simul: got hazard=%0b ovf=%0b unf=%0b expected 1/0/0", hazard, sb_ovf, sb_unf); end
        req_valid = 3'b001; tick(); req_valid = 3'b000;
        tick();
        checks++; if (hazard !== 1'b0) begin fails++; $display("FAIL haz_simul_kept1: got %0b expected 0", hazard); end
    endtask

    task automatic test_addr0();
        do_reset();
        set_req(0, 5'd0, 32'h1234);
        req_valid = 3'b001; reserve_valid = 1'b1; reserve_addr = 5'd0;
        #1;
        checks++; if (ready !== 3'b001 || hazard !== 1'b0) begin
            fails++; $display("FAIL a0_grant: got ready=%b hazard=%0b expected 001/0", ready, hazard); end
        tick();
        req_valid = '0; reserve_valid = 1'b0;
        checks++; if (reg_write !== 1'b0 || write_data !== 32'h1234 || hazard !== 1'b0) begin
            fails++; $display("FAIL a0_stage: got we=%0b wd=%0h hazard=%0b expected 0/1234/0", reg_write, write_data, hazard); end
        tick();
        checks++; if (sb_ovf !== 1'b0 || sb_unf !== 1'b0 || hazard !== 1'b0) begin
            fails++; $display("FAIL a0_flags: got ovf=%0b unf=%0b hazard=%0b expected 0/0/0", sb_ovf, sb_unf, hazard); end
    endtask

    task automatic test_flags();
        do_reset();
        check1 = 5'd3;
        for (int i = 0; i < 8; i++) begin
            reserve_valid = 1'b1; reserve_addr = 5'd3;
            tick();
            checks++; if (sb_ovf !== (i == 7)) begin
                fails++; $display("FAIL ovf_after%0d: got %0b expected %0b", i + 1, sb_ovf, (i == 7)); end
        end
        reserve_valid = 1'b0;
        set_req(2, 5'd9, 32'h99);
        req_valid = 3'b100; tick(); req_valid = 3'b000;
        checks++; if (sb_unf !== 1'b0) begin fails++; $display("FAIL unf_early: got %0b expected 0", sb_unf); end
        tick();
        checks++; if (sb_unf !== 1'b1) begin fails++; $display("FAIL unf_set: got %0b expected 1", sb_unf); end
        set_req(0, 5'd4, 32'hCAFE);
        req_valid = 3'b001; tick(); req_valid = 3'b000;
        checks++; if (reg_write !== 1'b1) begin fails++; $display("FAIL mid_pre: got %0b expected 1", reg_write); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (reg_write !== 1'b0 || sb_ovf !== 1'b0 || sb_unf !== 1'b0 || hazard !== 1'b0 || write_data !== '0) begin
            fails++; $display("FAIL mid_reset: got we=%0b ovf=%0b unf=%0b hazard=%0b wd=%0h expected all 0", reg_write, sb_ovf, sb_unf, hazard, write_data); end
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int g;
        logic [NREQ-1:0] exp_r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            checks++; if (reg_write !== m_we || (m_we && (write_register !== AW'(m_wr) || write_data !== m_wd))) begin
                fails++; $display("FAIL rnd_write c%0d: got we=%0b wr=%0d wd=%0h expected %0b/%0d/%0h", c, reg_write, write_register, write_data, m_we, m_wr, m_wd); end
            checks++; if (sb_ovf !== m_ovf || sb_unf !== m_unf) begin
                fails++; $display("FAIL rnd_flags c%0d: got ovf=%0b unf=%0b expected %0b/%0b", c, sb_ovf, sb_unf, m_ovf, m_unf); end
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    set_req(i, AW'($urandom_range(0, 7)), $urandom);
                end
            end
            reserve_valid = ($urandom_range(0, 2) == 0);
            reserve_addr  = AW'($urandom_range(0, 7));
            check1 = AW'($urandom_range(0, 7)); check2 = AW'($urandom_range(0, 7));
            #1;
            g = model_grant();
            exp_r = '0;
            if (g >= 0) exp_r[g] = 1'b1;
            checks++; if (ready !== exp_r) begin
                fails++; $display("FAIL rnd_grant c%0d: got %b expected %b", c, ready, exp_r); end
            checks++; if (hazard !== model_hazard()) begin
                fails++; $display("FAIL rnd_hazard c%0d: got %0b expected %0b", c, hazard, model_hazard()); end
            model_step();
            tick();
            if (g >= 0) req_valid[g] = 1'b0;
        end
    endtask

    initial begin
        clr_inputs();
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_hazard();
        test_addr0();
        test_flags();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port between NREQ writeback requesters, for example ALU, load and multiply/divide. Each cycle it grants one requester and drives a registered write into the register file, which writes on the falling edge of `clk`. It also keeps a pending-write scoreboard: the issue stage reserves destinations, and a combinational `hazard` flag tells it when a source register still has a write in flight.

## Interface
Parameters:
- NREQ, 3, number of writeback requesters (2..8)
- DW, 32, data width
- AW, 5, register address width (2^AW registers)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- reqValid  in  NREQ  requester i has a write pending
- reqAddr  in  NREQ*AW  destination of requester i, slice [i*AW +: AW]
- reqData  in  NREQ*DW  data of requester i, slice [i*DW +: DW]
- reqReady  out  NREQ  one-hot grant, combinational
- reserveValid  in  1  issue stage reserves a destination this cycle
- reserveAddr  in  AW  destination being reserved
- checkAddr1, checkAddr2  in  AW  source registers to hazard-check
- hazard  out  1  a pending write exists to checkAddr1 or checkAddr2, combinational
- regWrite  out  1  register-file write enable, registered
- writeRegister  out  AW  register-file write address, registered
- writeData  out  DW  register-file write data, registered
- sbOverflow  out  1  sticky flag: a reservation hit a saturated counter
- sbUnderflow  out  1  sticky flag: a retire hit a zero counter

## Operation
Arbitration:
- At most one bit of reqReady is high per cycle, and only for a requester with reqValid=1.
- reqReady depends only on reqValid and the internal pointer, never on any other input.
- A transfer occurs when reqValid[i]=1 and reqReady[i]=1. A requester holds its addr/data stable until it sees its transfer.
- Round-robin order: the search starts at index ptr+1 modulo NREQ. The first valid requester found wins. On a transfer, ptr is set to the granted index; with no transfer, ptr is unchanged.

Write stage:
- On a transfer, the next rising edge loads writeRegister/writeData from the winner.
- regWrite=1 for exactly that one cycle, unless the address is 0. An address-0 transfer is still accepted and retired, but regWrite stays 0.
- With no transfer, regWrite=0 and writeRegister/writeData hold their values.

Scoreboard:
- One 3-bit pending counter per register; register 0 has no counter and always reads 0.
- Reserve: reserveValid=1 with reserveAddr!=0 increments that counter. If the counter is already 7, it stays at 7 and sbOverflow is set.
- Retire: a write-stage cycle that carries a transfer, with non-zero address, decrements that counter. If the counter is already 0, it stays at 0 and sbUnderflow is set.
- A reserve and a retire on the same register in the same cycle leave the counter unchanged.
- hazard = (cnt[checkAddr1]!=0) | (cnt[checkAddr2]!=0).

Reset, asynchronous and immediate:
- regWrite=0, writeRegister=0, writeData=0.
- All counters 0, ptr=NREQ-1, so index 0 is first served.
- sbOverflow=0, sbUnderflow=0.
- An in-flight write stage is discarded, with no write and no retire.

## Timing
- Grant is the same cycle as the request; there are no wait states when uncontended.
- Transfer at rising edge N:
  - The write stage is valid from N to N+1.
  - The register file writes at the falling edge between them.
  - The counter decrements at N+1.
  - hazard for that register drops in the cycle after N+1, when the register-file read already returns the new data.
- A reserve at edge N makes hazard visible in the cycle after N.
- Throughput is one write per cycle. A requester waiting behind k others is granted within NREQ-1 cycles of becoming eligible (round-robin).

## Configuration
- RR_ARB_EN defined: round-robin arbitration as described above.
- RR_ARB_EN undefined:
  - Fixed priority: the lowest valid index always wins.
  - ptr is not implemented.
  - Starvation of higher indices is permitted.
  - All other behaviour is identical.

## Test plan
- Reset, then all idle: regWrite=0, writeRegister=0, writeData=0, hazard=0 and reqReady=0 every cycle.
- Requester 1 alone, addr 5, data 0xDEADBEEF: reqReady=3'b010 in the same cycle. Next cycle regWrite=1, writeRegister=5, writeData=0xDEADBEEF for exactly one cycle.
- All three requesters held valid for 6 cycles with RR_ARB_EN:
  - Grants follow 0,1,2,0,1,2 and one write per cycle.
  - Without the macro, six grants go to index 0.
- Reserve r7 twice, check r7: hazard=1.
  - After the first retire of r7, hazard is still 1.
  - After the second retire, hazard=0 in the cycle after that write stage.
  - Simultaneous reserve and retire of r7 keeps the count.
- Addr-0 write plus reserveAddr=0: the request is accepted, regWrite stays 0, hazard with checkAddr1=0 stays 0, and the flags stay 0.
- Eight reserves of r3: sbOverflow=1 after the eighth. Retire of r9 with count 0: sbUnderflow=1. rst_n low mid-write clears both flags and regWrite immediately.
